// File: rtl/clk_gate_ctrl.sv
// Idle-driven clock-gate controller: RUN -> GATED after IDLE_CYCLES idle cycles, GATED -> WAKE -> RUN.
// Optional gated-cycle statistics counter enabled by macro CLK_GATE_CTRL_STATS_EN.
module clk_gate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        auto_en,
    input  logic        force_on,
    input  logic        busy,
    input  logic        wake_req,
    input  logic        stats_clr,
    output logic        cg_en,
    output logic        clk_ready,
    output logic [1:0]  state_o,
    output logic [31:0] gated_cycles
);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] GATED = 2'd1;
    localparam logic [1:0] WAKE  = 2'd2;

    localparam logic [15:0] IDLE_LAST = 16'(IDLE_CYCLES - 1);
    localparam logic [7:0]  WAKE_LAST = 8'(WAKE_CYCLES - 1);

    logic [1:0]  state;
    logic [15:0] idle_cnt;
    logic [7:0]  wake_cnt;
    logic        run_idle;
    logic        wake_cond;

    assign run_idle  = auto_en & ~force_on & ~busy & ~wake_req;
    // busy is deliberately absent: gated logic cannot be busy without a clock.
    assign wake_cond = wake_req | force_on | ~auto_en;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= RUN;
            cg_en     <= 1'b1;
            clk_ready <= 1'b1;
            idle_cnt  <= '0;
            wake_cnt  <= '0;
        end else begin
            case (state)
                RUN: begin
                    cg_en     <= 1'b1;
                    clk_ready <= 1'b1;
                    wake_cnt  <= '0;
                    if (run_idle) begin
                        if (idle_cnt == IDLE_LAST) begin
                            state     <= GATED;
                            cg_en     <= 1'b0;
                            clk_ready <= 1'b0;
                            idle_cnt  <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 16'd1;
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                GATED: begin
                    cg_en     <= 1'b0;
                    clk_ready <= 1'b0;
                    idle_cnt  <= '0;
                    if (wake_cond) begin
                        state    <= WAKE;
                        cg_en    <= 1'b1;
                        wake_cnt <= '0;
                    end
                end
                WAKE: begin
                    // Wake sequence always runs to completion regardless of inputs.
                    cg_en     <= 1'b1;
                    clk_ready <= 1'b0;
                    idle_cnt  <= '0;
                    if (wake_cnt == WAKE_LAST) begin
                        state     <= RUN;
                        clk_ready <= 1'b1;
                        wake_cnt  <= '0;
                    end else begin
                        wake_cnt <= wake_cnt + 8'd1;
                    end
                end
                default: begin
                    state     <= RUN;
                    cg_en     <= 1'b1;
                    clk_ready <= 1'b1;
                    idle_cnt  <= '0;
                    wake_cnt  <= '0;
                end
            endcase
        end
    end

    assign state_o = state;

`ifdef CLK_GATE_CTRL_STATS_EN
    logic [31:0] stats_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stats_cnt <= '0;
        end else if (stats_clr) begin
            stats_cnt <= '0;
        end else if (state == GATED && stats_cnt != 32'hFFFF_FFFF) begin
            stats_cnt <= stats_cnt + 32'd1;
        end
    end

    assign gated_cycles = stats_cnt;
`else
    logic unused_stats_clr;

    assign unused_stats_clr = stats_clr;
    assign gated_cycles     = '0;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl with IDLE_CYCLES=4, WAKE_CYCLES=2.
// Covers gating, busy/wake interruption, wake sequencing, async reset and the optional statistics counter.
module tb_clk_gate_ctrl;

    logic        clk;
    logic        rstn;
    logic        auto_en;
    logic        force_on;
    logic        busy;
    logic        wake_req;
    logic        stats_clr;
    logic        cg_en;
    logic        clk_ready;
    logic [1:0]  state_o;
    logic [31:0] gated_cycles;

    int checks = 0;
    int errors = 0;

    clk_gate_ctrl #(
        .IDLE_CYCLES(4),
        .WAKE_CYCLES(2)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .auto_en      (auto_en),
        .force_on     (force_on),
        .busy         (busy),
        .wake_req     (wake_req),
        .stats_clr    (stats_clr),
        .cg_en        (cg_en),
        .clk_ready    (clk_ready),
        .state_o      (state_o),
        .gated_cycles (gated_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic e_cg, input logic e_rdy, input logic [1:0] e_st);
        check({tag, ".cg_en"},     32'(cg_en),     32'(e_cg));
        check({tag, ".clk_ready"}, 32'(clk_ready), 32'(e_rdy));
        check({tag, ".state_o"},   32'(state_o),   32'(e_st));
    endtask

    initial begin
        rstn      = 1'b0;
        auto_en   = 1'b1;
        force_on  = 1'b0;
        busy      = 1'b0;
        wake_req  = 1'b0;
        stats_clr = 1'b0;

        // Reset state
        step();
        step();
        check_outs("reset", 1'b1, 1'b1, 2'd0);
        check("reset.gated_cycles", gated_cycles, 32'd0);
        rstn = 1'b1;

        // Four idle cycles then gate
        for (int i = 1; i <= 3; i++) begin
            step();
            check_outs($sformatf("idle%0d", i), 1'b1, 1'b1, 2'd0);
        end
        step();
        check_outs("gate_entry", 1'b0, 1'b0, 2'd1);

        // busy is ignored while gated
        busy = 1'b1;
        step();
        check_outs("gated_busy", 1'b0, 1'b0, 2'd1);
        busy = 1'b0;

        // One-cycle wake_req: WAKE for two cycles, then RUN
        wake_req = 1'b1;
        step();
        check_outs("wake1", 1'b1, 1'b0, 2'd2);
        wake_req = 1'b0;
        step();
        check_outs("wake2", 1'b1, 1'b0, 2'd2);
        step();
        check_outs("wake_done", 1'b1, 1'b1, 2'd0);

        // busy at idle cycle 3 clears the count
        step();
        step();
        busy = 1'b1;
        step();
        check_outs("busy_pulse", 1'b1, 1'b1, 2'd0);
        busy = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check_outs($sformatf("post_busy%0d", i), 1'b1, 1'b1, 2'd0);
        end
        step();
        check_outs("post_busy_gate", 1'b0, 1'b0, 2'd1);

        // auto_en low wakes; inputs during WAKE do not abort it
        auto_en = 1'b0;
        step();
        check_outs("auto_off_wake", 1'b1, 1'b0, 2'd2);
        auto_en = 1'b1;
        force_on = 1'b1;
        step();
        check_outs("wake_no_abort", 1'b1, 1'b0, 2'd2);
        force_on = 1'b0;
        step();
        check_outs("auto_wake_done", 1'b1, 1'b1, 2'd0);

        // wake_req coincident with 4th idle cycle keeps RUN and clears the count
        step();
        step();
        step();
        wake_req = 1'b1;
        step();
        check_outs("thresh_wake", 1'b1, 1'b1, 2'd0);
        wake_req = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check_outs($sformatf("after_thresh%0d", i), 1'b1, 1'b1, 2'd0);
        end
        step();
        check_outs("after_thresh_gate", 1'b0, 1'b0, 2'd1);

        // Async reset during WAKE
        wake_req = 1'b1;
        step();
        check_outs("pre_rst_wake", 1'b1, 1'b0, 2'd2);
        wake_req = 1'b0;
        #1 rstn = 1'b0;
        #1;
        check_outs("async_rst", 1'b1, 1'b1, 2'd0);
        #4 rstn = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check_outs($sformatf("post_rst%0d", i), 1'b1, 1'b1, 2'd0);
        end
        step();
        check_outs("post_rst_gate", 1'b0, 1'b0, 2'd1);

`ifdef CLK_GATE_CTRL_STATS_EN
        // One GATED edge has elapsed (the entry edge does not count); clear wins over increment
        stats_clr = 1'b1;
        step();
        check("stats_clr", gated_cycles, 32'd0);
        stats_clr = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("stats_ten", gated_cycles, 32'd10);
        dut.stats_cnt = 32'hFFFF_FFFE;
        step();
        check("stats_max", gated_cycles, 32'hFFFF_FFFF);
        step();
        check("stats_sat", gated_cycles, 32'hFFFF_FFFF);
`else
        for (int i = 0; i < 10; i++) step();
        check("stats_off_ten", gated_cycles, 32'd0);
        stats_clr = 1'b1;
        step();
        check("stats_off_clr", gated_cycles, 32'd0);
        stats_clr = 1'b0;
`endif
        check_outs("still_gated", 1'b0, 1'b0, 2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 The block SHALL have parameter IDLE_CYCLES, default 16, consecutive idle cycles before gating; legal range 1..65535.
REQ-002 The block SHALL have parameter WAKE_CYCLES, default 2, cycles from clock restart to ready; legal range 1..255.
REQ-003 The block SHALL have port clk  input  1  free-running source clock, also the clock fed to the downstream tech_cg.
REQ-004 The block SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port auto_en  input  1  automatic gating permitted.
REQ-006 The block SHALL have port force_on  input  1  keep clock running, overrides idle detection.
REQ-007 The block SHALL have port busy  input  1  gated subsystem activity, synchronous to clk.
REQ-008 The block SHALL have port wake_req  input  1  request to restart or keep the clock.
REQ-009 The block SHALL have port stats_clr  input  1  clear the gated-cycle counter.
REQ-010 The block SHALL have port cg_en  output  1  enable to tech_cg.en, registered.
REQ-011 The block SHALL have port clk_ready  output  1  gated clock stable and usable.
REQ-012 The block SHALL have port state_o  output  2  FSM state: RUN=0, GATED=1, WAKE=2.
REQ-013 The block SHALL have port gated_cycles  output  32  count of cycles spent in GATED.

Function
REQ-014 The FSM SHALL have states RUN, GATED and WAKE; encoding 3 is unreachable and SHALL recover to RUN on the next edge.
REQ-015 cg_en, clk_ready and state_o SHALL be driven directly from flops, with no combinational path from any input.
REQ-016 A RUN cycle SHALL be idle when auto_en=1, force_on=0, busy=0 and wake_req=0; any non-idle cycle SHALL clear the 16-bit idle counter to 0.
REQ-017 In RUN, cg_en=1 and clk_ready=1; on the edge ending the IDLE_CYCLES-th consecutive idle cycle, the FSM SHALL enter GATED with cg_en=0 and clk_ready=0.
REQ-018 If the cycle that would reach the threshold is not idle (e.g. wake_req=1 or busy=1 arrives simultaneously), the FSM SHALL stay in RUN and clear the counter.
REQ-019 In GATED, busy SHALL be ignored; wake_req=1, force_on=1 or auto_en=0 SHALL move the FSM to WAKE on the next edge, with cg_en=1 from that edge.
REQ-020 In WAKE, cg_en=1 and clk_ready=0; the 8-bit wake counter SHALL count WAKE_CYCLES cycles, then the FSM SHALL enter RUN with clk_ready=1 and the idle counter at 0.
REQ-021 Inputs in WAKE SHALL NOT abort the wake sequence; return to GATED SHALL only occur from RUN.
REQ-022 cg_en SHALL change only on rising clk edges, so it is stable through the clk-low transparent phase of the downstream latch.

Reset
REQ-023 While rstn=0, the block SHALL hold state RUN, cg_en=1, clk_ready=1, state_o=0, idle and wake counters at 0, and gated_cycles=0.
REQ-024 Reset asserted in GATED or WAKE SHALL immediately force the REQ-023 values; after release, the idle count SHALL restart from 0.

Configuration
REQ-025 With macro CLK_GATE_CTRL_STATS_EN defined, gated_cycles SHALL increment by 1 on every edge where state is GATED and SHALL saturate at 32'hFFFF_FFFF.
REQ-026 With CLK_GATE_CTRL_STATS_EN defined, stats_clr=1 SHALL set gated_cycles to 0 on the next edge, taking priority over increment.
REQ-027 Without CLK_GATE_CTRL_STATS_EN, gated_cycles SHALL be tied to 0, stats_clr SHALL be ignored, and no counter flops SHALL be instantiated.

Verification
All scenarios use IDLE_CYCLES=4 and WAKE_CYCLES=2.
REQ-028 Reset with auto_en=1 and all other inputs 0 -> cg_en=1 for 4 idle cycles after release, cg_en=0 and state_o=1 at the 4th edge.
REQ-029 busy pulsed high at idle cycle 3 -> counter clears; gating occurs only 4 full idle cycles after busy falls.
REQ-030 In GATED, wake_req pulsed for 1 cycle -> next edge gives cg_en=1 and state_o=2, clk_ready=1 two edges later, state_o=0.
REQ-031 wake_req coincident with the 4th idle cycle -> state stays RUN and cg_en never drops.
REQ-032 rstn pulsed low for half a cycle while in WAKE -> cg_en=1, clk_ready=1 and state_o=0 asynchronously, before the next edge.
REQ-033 With the macro defined, 10 cycles in GATED -> gated_cycles=10; stats_clr -> 0; preload near the maximum -> value holds at 32'hFFFF_FFFF; without the macro -> gated_cycles stays 0.
